// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage sequencer: hazard stalls, flushes, halt drain, perf counters
module fetch_ctrl #(
  parameter logic [31:0] HALT_WORD    = 32'hffffffff,
  parameter int          DRAIN_CYCLES = 7,
  parameter int          CNT_W        = 32
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [31:0]      inst_in,
  input  logic             load_use,
  input  logic             bj_wait,
  input  logic             bj_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             fin_sign,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0]       DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       drain_q, drain_d;
  logic             fin_q, fin_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stl_q, stl_d;
  logic [CNT_W-1:0] fls_q, fls_d;
  logic             pc_stall_c, ifid_stall_c, ifid_flush_c;

  // Control decode and next-state: hazards beat taken branches, which beat halt detection
  always_comb begin
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    fin_d        = fin_q;
    case (state_q)
      ST_RUN: begin
        if (load_use || bj_wait) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
        end else if (bj_taken) begin
          ifid_flush_c = 1'b1;
        end else if (inst_in == HALT_WORD) begin
          pc_stall_c   = 1'b1;
          ifid_flush_c = 1'b1;
          state_d      = ST_DRAIN;
          drain_d      = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        pc_stall_c   = 1'b1;
        ifid_flush_c = 1'b1;
        if (drain_q == 8'd0) begin
          state_d = ST_DONE;
          fin_d   = 1'b1;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      ST_DONE: begin
        pc_stall_c   = 1'b1;
        ifid_flush_c = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Saturating counters: cycles until DONE, stalls and flushes only while running
  always_comb begin
    cyc_d = cyc_q;
    stl_d = stl_q;
    fls_d = fls_q;
    if (state_q != ST_DONE && cyc_q != CNT_MAX) begin
      cyc_d = cyc_q + CNT_ONE;
    end
    if (state_q == ST_RUN && pc_stall_c && stl_q != CNT_MAX) begin
      stl_d = stl_q + CNT_ONE;
    end
    if (state_q == ST_RUN && ifid_flush_c && fls_q != CNT_MAX) begin
      fls_d = fls_q + CNT_ONE;
    end
  end

  // State, drain counter, finish flag and counters
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_RUN;
      drain_q <= 8'd0;
      fin_q   <= 1'b0;
      cyc_q   <= '0;
      stl_q   <= '0;
      fls_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      fin_q   <= fin_d;
      cyc_q   <= cyc_d;
      stl_q   <= stl_d;
      fls_q   <= fls_d;
    end
  end

  // Pipeline controls are forced low while reset is held
  assign pc_stall   = RESET_N & pc_stall_c;
  assign ifid_stall = RESET_N & ifid_stall_c;
  assign ifid_flush = RESET_N & ifid_flush_c;
  assign fin_sign   = fin_q;
  assign cycle_cnt  = cyc_q;
  assign stall_cnt  = stl_q;
  assign flush_cnt  = fls_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

  localparam logic [31:0] HALT = 32'hffffffff;
  localparam int          DC   = 7;
  localparam longint      MAX32 = 64'hffffffff;
  localparam longint      MAX4  = 15;

  logic        CLOCK   = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] inst_in = 32'h0;
  logic        lu = 1'b0, bw = 1'b0, bt = 1'b0;

  logic        pc_a, st_a, fl_a, fin_a;
  logic [31:0] cyc_a, stl_a, fls_a;
  logic        pc_b, st_b, fl_b, fin_b;
  logic [3:0]  cyc_b, stl_b, fls_b;

  fetch_ctrl #(.HALT_WORD(HALT), .DRAIN_CYCLES(DC), .CNT_W(32)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .inst_in(inst_in),
    .load_use(lu), .bj_wait(bw), .bj_taken(bt),
    .pc_stall(pc_a), .ifid_stall(st_a), .ifid_flush(fl_a), .fin_sign(fin_a),
    .cycle_cnt(cyc_a), .stall_cnt(stl_a), .flush_cnt(fls_a)
  );

  fetch_ctrl #(.HALT_WORD(HALT), .DRAIN_CYCLES(DC), .CNT_W(4)) dut4 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .inst_in(inst_in),
    .load_use(lu), .bj_wait(bw), .bj_taken(bt),
    .pc_stall(pc_b), .ifid_stall(st_b), .ifid_flush(fl_b), .fin_sign(fin_b),
    .cycle_cnt(cyc_b), .stall_cnt(stl_b), .flush_cnt(fls_b)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: program phase flags, remaining drain cycles, unbounded event counts
  bit     m_drain, m_done, m_fin;
  int     m_left;
  longint t_cyc, t_stl, t_fls;
  bit     e_pc, e_st, e_fl;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_drain = 0; m_done = 0; m_fin = 0; m_left = 0;
    t_cyc = 0; t_stl = 0; t_fls = 0;
  endtask

  task automatic model_comb();
    e_pc = 0; e_st = 0; e_fl = 0;
    if (!RESET_N) begin
      e_pc = 0;
    end else if (m_drain || m_done) begin
      e_pc = 1; e_fl = 1;
    end else if (lu || bw) begin
      e_pc = 1; e_st = 1;
    end else if (bt) begin
      e_fl = 1;
    end else if (inst_in == HALT) begin
      e_pc = 1; e_fl = 1;
    end
  endtask

  task automatic model_step();
    model_comb();
    if (!RESET_N) begin
      model_reset();
    end else begin
      if (!m_done) t_cyc++;
      if (!m_drain && !m_done) begin
        if (e_pc) t_stl++;
        if (e_fl) t_fls++;
      end
      if (m_drain) begin
        m_left--;
        if (m_left == 0) begin
          m_drain = 0; m_done = 1; m_fin = 1;
        end
      end else if (!m_done && !(lu || bw) && !bt && inst_in == HALT) begin
        m_drain = 1; m_left = DC;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    model_comb();
    chk({tag, ".pc_stall"},   pc_a,  e_pc);
    chk({tag, ".ifid_stall"}, st_a,  e_st);
    chk({tag, ".ifid_flush"}, fl_a,  e_fl);
    chk({tag, ".fin"},        fin_a, m_fin);
    chk({tag, ".cycle_cnt"},  cyc_a, sat(t_cyc, MAX32));
    chk({tag, ".stall_cnt"},  stl_a, sat(t_stl, MAX32));
    chk({tag, ".flush_cnt"},  fls_a, sat(t_fls, MAX32));
    chk({tag, ".w4.pc_stall"},   pc_b,  e_pc);
    chk({tag, ".w4.ifid_stall"}, st_b,  e_st);
    chk({tag, ".w4.ifid_flush"}, fl_b,  e_fl);
    chk({tag, ".w4.fin"},        fin_b, m_fin);
    chk({tag, ".w4.cycle_cnt"},  cyc_b, sat(t_cyc, MAX4));
    chk({tag, ".w4.stall_cnt"},  stl_b, sat(t_stl, MAX4));
    chk({tag, ".w4.flush_cnt"},  fls_b, sat(t_fls, MAX4));
  endtask

  task automatic cycle(input bit rst, input logic [31:0] w, input bit l, input bit b,
                       input bit t, input string tag);
    @(negedge CLOCK);
    RESET_N = rst; inst_in = w; lu = l; bw = b; bt = t;
    if (!rst) model_reset();
    #1 check_all(tag);
    @(posedge CLOCK);
    model_step();
  endtask

  task automatic async_pulse(input string tag);
    @(negedge CLOCK);
    inst_in = 32'h0; lu = 0; bw = 0; bt = 0;
    #2 RESET_N = 0;
    model_reset();
    #1 check_all(tag);
    #1 RESET_N = 1;
    @(posedge CLOCK);
    model_step();
  endtask

  function automatic logic [31:0] rnd_word();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return HALT;
    if (sel == 1) return 32'hfffffffe;
    if (sel == 2) return 32'h7fffffff;
    return $urandom();
  endfunction

  initial begin
    model_reset();

    for (int i = 0; i < 3; i++) cycle(0, HALT, 1, 1, 1, "reset");

    for (int i = 0; i < 10; i++) cycle(1, 32'h1000_0000 + 32'(i), 0, 0, 0, "plain");
    #1;
    chk("plain.cycle_cnt10", cyc_a, 10);
    chk("plain.stall_cnt0",  stl_a, 0);
    chk("plain.flush_cnt0",  fls_a, 0);

    cycle(1, HALT, 0, 0, 1, "bjt_halt");
    #1;
    chk("bjt_halt.fin0",      fin_a, 0);
    chk("bjt_halt.flush_cnt", fls_a, 1);

    cycle(1, HALT, 1, 0, 0, "lu_halt");
    cycle(1, HALT, 1, 0, 0, "lu_halt");
    #1;
    chk("lu_halt.stall_cnt2", stl_a, 2);

    cycle(1, HALT, 0, 0, 0, "halt_detect");
    for (int k = 1; k <= DC; k++) begin
      cycle(1, $urandom(), 1'($urandom()), 1'($urandom()), 1'($urandom()), "drain");
      #1 chk("drain.fin_timing", fin_a, (k == DC) ? 1 : 0);
    end
    chk("done.cycle_cnt21", cyc_a, 21);
    chk("done.w4_cycle_sat", cyc_b, 15);
    for (int i = 0; i < 5; i++)
      cycle(1, $urandom(), 1'($urandom()), 1'($urandom()), 1'($urandom()), "done");
    #1 chk("done.cycle_frozen", cyc_a, 21);

    async_pulse("pulse_done");
    cycle(1, HALT, 0, 0, 0, "halt2");
    for (int i = 0; i < 3; i++) cycle(1, 32'h0, 0, 0, 0, "drain2");
    async_pulse("pulse_drain");

    for (int i = 0; i < 20; i++) cycle(1, 32'h2400_0001, 1, 0, 0, "sat");
    #1;
    chk("sat.stall20",    stl_a, 20);
    chk("sat.w4_stall_f", stl_b, 4'hf);

    cycle(1, 32'hfffffffe, 0, 0, 0, "partial");
    cycle(1, 32'h7fffffff, 0, 0, 0, "partial");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_pulse("rnd_pulse");
      end else begin
        cycle(1, rnd_word(), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
